// File: rtl/vga_timing_gen.sv
// vga_timing_gen: video timing generator for the VGA/LCD controller.
// Produces hsync/vsync/csync/blank/de plus eol/eof/hint/vint strobes from
// the N-1 encoded horizontal and vertical timing fields.
// Optional macro VGA_TGEN_SHADOW_EN: latch all timing fields into shadow
// registers at frame start so mid-frame writes apply from the next frame.
module vga_timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             ven,
    input  logic             hsl,
    input  logic             vsl,
    input  logic             csl,
    input  logic             bl,
    input  logic [7:0]       Thsync,
    input  logic [7:0]       Thgdel,
    input  logic [CNT_W-1:0] Thgate,
    input  logic [CNT_W-1:0] Thlen,
    input  logic [7:0]       Tvsync,
    input  logic [7:0]       Tvgdel,
    input  logic [CNT_W-1:0] Tvgate,
    input  logic [CNT_W-1:0] Tvlen,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             csync_o,
    output logic             blank_o,
    output logic             de_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic             hint_o,
    output logic             vint_o
);

    typedef enum logic [2:0] {H_IDLE, H_SYNC, H_GDEL, H_GATE, H_FP} hstate_t;
    typedef enum logic [2:0] {V_IDLE, V_SYNC, V_GDEL, V_GATE, V_FP} vstate_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hstate_t          hState_q;
    vstate_t          vState_q;
    logic [CNT_W-1:0] hPhase_q;
    logic [CNT_W-1:0] lineCnt_q;
    logic [CNT_W-1:0] vPhase_q;
    logic [CNT_W-1:0] frameCnt_q;
    logic             hEntry_q;
    logic             vEntry_q;

    logic             hsync_q;
    logic             vsync_q;
    logic             csync_q;
    logic             blank_q;
    logic             de_q;
    logic             eol_q;
    logic             eof_q;
    logic             hint_q;
    logic             vint_q;

    // Timing values actually seen by the FSMs (live inputs or shadows)
    logic [CNT_W-1:0] hSyncLen;
    logic [CNT_W-1:0] hGdelLen;
    logic [CNT_W-1:0] hGateLen;
    logic [CNT_W-1:0] hLineLen;
    logic [CNT_W-1:0] vSyncLen;
    logic [CNT_W-1:0] vGdelLen;
    logic [CNT_W-1:0] vGateLen;
    logic [CNT_W-1:0] vFrameLen;

    logic             startFrame;
    logic             lineEnd;
    logic             frameEnd;

    assign startFrame = ven && (hState_q == H_IDLE);
    assign lineEnd    = (hState_q != H_IDLE) && (lineCnt_q == hLineLen);
    assign frameEnd   = lineEnd && (frameCnt_q == vFrameLen);

`ifdef VGA_TGEN_SHADOW_EN
    logic [7:0]       shThsync_q;
    logic [7:0]       shThgdel_q;
    logic [CNT_W-1:0] shThgate_q;
    logic [CNT_W-1:0] shThlen_q;
    logic [7:0]       shTvsync_q;
    logic [7:0]       shTvgdel_q;
    logic [CNT_W-1:0] shTvgate_q;
    logic [CNT_W-1:0] shTvlen_q;
    logic             loadShadow;

    assign loadShadow = startFrame || (ven && frameEnd);

    // Capture the timing fields at frame start; the sync-width loads that
    // happen on that same edge bypass the shadows so the new frame is
    // consistent from its first cycle.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            shThsync_q <= '0;
            shThgdel_q <= '0;
            shThgate_q <= '0;
            shThlen_q  <= '0;
            shTvsync_q <= '0;
            shTvgdel_q <= '0;
            shTvgate_q <= '0;
            shTvlen_q  <= '0;
        end else if (loadShadow) begin
            shThsync_q <= Thsync;
            shThgdel_q <= Thgdel;
            shThgate_q <= Thgate;
            shThlen_q  <= Thlen;
            shTvsync_q <= Tvsync;
            shTvgdel_q <= Tvgdel;
            shTvgate_q <= Tvgate;
            shTvlen_q  <= Tvlen;
        end
    end

    assign hSyncLen  = loadShadow ? {{(CNT_W-8){1'b0}}, Thsync}
                                  : {{(CNT_W-8){1'b0}}, shThsync_q};
    assign hGdelLen  = {{(CNT_W-8){1'b0}}, shThgdel_q};
    assign hGateLen  = shThgate_q;
    assign hLineLen  = shThlen_q;
    assign vSyncLen  = loadShadow ? {{(CNT_W-8){1'b0}}, Tvsync}
                                  : {{(CNT_W-8){1'b0}}, shTvsync_q};
    assign vGdelLen  = {{(CNT_W-8){1'b0}}, shTvgdel_q};
    assign vGateLen  = shTvgate_q;
    assign vFrameLen = shTvlen_q;
`else
    assign hSyncLen  = {{(CNT_W-8){1'b0}}, Thsync};
    assign hGdelLen  = {{(CNT_W-8){1'b0}}, Thgdel};
    assign hGateLen  = Thgate;
    assign hLineLen  = Thlen;
    assign vSyncLen  = {{(CNT_W-8){1'b0}}, Tvsync};
    assign vGdelLen  = {{(CNT_W-8){1'b0}}, Tvgdel};
    assign vGateLen  = Tvgate;
    assign vFrameLen = Tvlen;
`endif

    // Horizontal FSM: phase down-counter plus free line counter; line end
    // forces a new SYNC from any state, truncating misprogrammed lines.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            hState_q  <= H_IDLE;
            hPhase_q  <= '0;
            lineCnt_q <= '0;
            hEntry_q  <= 1'b0;
        end else if (!ven) begin
            hState_q  <= H_IDLE;
            hPhase_q  <= '0;
            lineCnt_q <= '0;
            hEntry_q  <= 1'b0;
        end else if (hState_q == H_IDLE || lineEnd) begin
            hState_q  <= H_SYNC;
            hPhase_q  <= hSyncLen;
            lineCnt_q <= '0;
            hEntry_q  <= 1'b1;
        end else begin
            lineCnt_q <= lineCnt_q + ONE;
            hEntry_q  <= 1'b0;
            case (hState_q)
                H_SYNC: begin
                    if (hPhase_q == '0) begin
                        hState_q <= H_GDEL;
                        hPhase_q <= hGdelLen;
                    end else begin
                        hPhase_q <= hPhase_q - ONE;
                    end
                end
                H_GDEL: begin
                    if (hPhase_q == '0) begin
                        hState_q <= H_GATE;
                        hPhase_q <= hGateLen;
                    end else begin
                        hPhase_q <= hPhase_q - ONE;
                    end
                end
                H_GATE: begin
                    if (hPhase_q == '0) begin
                        hState_q <= H_FP;
                    end else begin
                        hPhase_q <= hPhase_q - ONE;
                    end
                end
                H_FP:    hState_q <= H_FP;
                default: hState_q <= H_IDLE;
            endcase
        end
    end

    // Vertical FSM: same phase rules as horizontal, stepping once per line
    // end and restarting at SYNC on frame end.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            vState_q   <= V_IDLE;
            vPhase_q   <= '0;
            frameCnt_q <= '0;
            vEntry_q   <= 1'b0;
        end else if (!ven) begin
            vState_q   <= V_IDLE;
            vPhase_q   <= '0;
            frameCnt_q <= '0;
            vEntry_q   <= 1'b0;
        end else if (vState_q == V_IDLE || frameEnd) begin
            vState_q   <= V_SYNC;
            vPhase_q   <= vSyncLen;
            frameCnt_q <= '0;
            vEntry_q   <= 1'b1;
        end else if (lineEnd) begin
            frameCnt_q <= frameCnt_q + ONE;
            vEntry_q   <= 1'b0;
            case (vState_q)
                V_SYNC: begin
                    if (vPhase_q == '0) begin
                        vState_q <= V_GDEL;
                        vPhase_q <= vGdelLen;
                    end else begin
                        vPhase_q <= vPhase_q - ONE;
                    end
                end
                V_GDEL: begin
                    if (vPhase_q == '0) begin
                        vState_q <= V_GATE;
                        vPhase_q <= vGateLen;
                    end else begin
                        vPhase_q <= vPhase_q - ONE;
                    end
                end
                V_GATE: begin
                    if (vPhase_q == '0) begin
                        vState_q <= V_FP;
                    end else begin
                        vPhase_q <= vPhase_q - ONE;
                    end
                end
                V_FP:    vState_q <= V_FP;
                default: vState_q <= V_IDLE;
            endcase
        end else begin
            vEntry_q <= 1'b0;
        end
    end

    // Output registers: decode FSM states, apply polarity and register the
    // strobes so everything lags the FSM state by exactly one cycle.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            csync_q <= 1'b0;
            blank_q <= 1'b0;
            de_q    <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            hint_q  <= 1'b0;
            vint_q  <= 1'b0;
        end else begin
            hsync_q <= (hState_q == H_SYNC) ^ hsl;
            vsync_q <= (vState_q == V_SYNC) ^ vsl;
            csync_q <= ((hState_q == H_SYNC) || (vState_q == V_SYNC)) ^ csl;
            blank_q <= !((hState_q == H_GATE) && (vState_q == V_GATE)) ^ bl;
            de_q    <= (hState_q == H_GATE) && (vState_q == V_GATE);
            eol_q   <= lineEnd;
            eof_q   <= frameEnd;
            hint_q  <= hEntry_q;
            vint_q  <= vEntry_q;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign csync_o = csync_q;
    assign blank_o = blank_q;
    assign de_o    = de_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;
    assign hint_o  = hint_q;
    assign vint_o  = vint_q;

endmodule
